fpcsr_mc: RTL and testbench

- Multi-lane floating-point CSR unit that holds fflags and frm and serves the fflags (0x001), frm (0x002) and fcsr (0x003) views.
- Accepts NLANE in-order commit lanes per cycle. Lane 0 is the oldest; its effects are applied first.
- Supports CSR write, set and clear operations. Tracks the mstatus.FS dirty condition.
- Stalls FP issue for a fixed number of cycles after frm changes, and resolves dynamic rounding mode for the decoder.

---
 rtl/fpcsr_mc.sv | 180 ++++++++++++++++++
 tb/tb_fpcsr_mc.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fpcsr_mc.sv
// fpcsr_mc: floating-point CSR unit with NLANE in-order commit lanes.
// It holds fflags and frm and serves the fflags (0x001), frm (0x002) and
// fcsr (0x003) views.
//
// Ports:
//   clk_i, srst_i        clock and synchronous active-high reset
//   valid_i, csren_i     per-lane commit valid, and a flag saying the lane carries a CSR op
//   csrop_i              per-lane op: 01 write, 10 set, 11 clear, 00 no-op
//   csrindex_i           per-lane CSR index
//   csrdata_i            per-lane source operand
//   fflagen_i, fflag_i   per-lane exception-flag accrual, bits {NV,DZ,OF,UF,NX}
//   fs_clr_i             clears fs_dirty_o
//   rd_index_i           read index; rd_data_o and rd_hit_o are the read result
//   fcsr_o, frm_o, fflags_o   current register state
//   fs_dirty_o           FP state has been modified
//   frm_stall_o          hold FP issue while a new frm propagates
//   rm_i                 instruction rm field
//   rm_eff_o, rm_illegal_o    resolved rounding mode, and a flag for reserved modes

// One commit lane. It takes {frm, fflags} as left by the older lanes and
// returns the state after this lane's effect.
module fpcsr_lane (
  input  logic        valid,
  input  logic        csren,
  input  logic [1:0]  op,
  input  logic [11:0] idx,
  input  logic [7:0]  data,
  input  logic        fflagen,
  input  logic [4:0]  fflag,
  input  logic [2:0]  frm_in,
  input  logic [4:0]  ffl_in,
  output logic [2:0]  frm_out,
  output logic [4:0]  ffl_out,
  output logic        touch
);
  logic       csr_hit;
  logic [7:0] cur, f, mask, res, nxt;

  assign csr_hit = valid && csren && (op != 2'b00) &&
                   (idx == 12'h001 || idx == 12'h002 || idx == 12'h003);
  assign cur = {frm_in, ffl_in};

  // Each view is a masked window onto the combined 8-bit {frm, fflags} image.
  // Because of this, a single write/set/clear datapath serves all three views.
  always_comb begin
    f    = 8'h00;
    mask = 8'h00;
    case (idx)
      12'h001: begin f = {3'b000, data[4:0]}; mask = 8'h1f; end
      12'h002: begin f = {data[2:0], 5'b00000}; mask = 8'he0; end
      12'h003: begin f = data;                  mask = 8'hff; end
      default: ;
    endcase
    case (op)
      2'b01:   res = f;
      2'b10:   res = cur | f;
      2'b11:   res = cur & ~f;
      default: res = cur;
    endcase
    nxt = (cur & ~mask) | (res & mask);
  end

  always_comb begin
    frm_out = frm_in;
    ffl_out = ffl_in;
    touch   = 1'b0;
    if (csr_hit) begin
      // An accepted CSR op shadows this lane's own flag accrual.
      {frm_out, ffl_out} = nxt;
      touch = 1'b1;
    end else if (valid && fflagen) begin
      ffl_out = ffl_in | fflag;
      touch   = 1'b1;
    end
  end
endmodule

module fpcsr_mc #(
  parameter int       XLEN      = 64,
  parameter int       NLANE     = 2,
  parameter bit [2:0] FRM_RST   = 3'b000,
  parameter int       FLUSH_CYC = 2
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  input  logic [NLANE-1:0]            valid_i,
  input  logic [NLANE-1:0]            csren_i,
  input  logic [NLANE-1:0][1:0]       csrop_i,
  input  logic [NLANE-1:0][11:0]      csrindex_i,
  input  logic [NLANE-1:0][XLEN-1:0]  csrdata_i,
  input  logic [NLANE-1:0]            fflagen_i,
  input  logic [NLANE-1:0][4:0]       fflag_i,
  input  logic                        fs_clr_i,
  input  logic [11:0]                 rd_index_i,
  input  logic [2:0]                  rm_i,
  output logic [XLEN-1:0]             rd_data_o,
  output logic                        rd_hit_o,
  output logic [XLEN-1:0]             fcsr_o,
  output logic [2:0]                  frm_o,
  output logic [4:0]                  fflags_o,
  output logic                        fs_dirty_o,
  output logic                        frm_stall_o,
  output logic [2:0]                  rm_eff_o,
  output logic                        rm_illegal_o
);
  localparam int CW = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  logic [2:0]            frm_q;
  logic [4:0]            ffl_q;
  logic                  dirty_q;
  logic [CW-1:0]         cnt_q;

  // Lane chain: entry k is the state seen by lane k; entry NLANE is the final state.
  logic [NLANE:0][2:0]   frm_c;
  logic [NLANE:0][4:0]   ffl_c;
  logic [NLANE-1:0]      touch;
  logic [NLANE-1:0]      unused_hi;

  assign frm_c[0] = frm_q;
  assign ffl_c[0] = ffl_q;

  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    fpcsr_lane u_lane (
      .valid   (valid_i[g]),
      .csren   (csren_i[g]),
      .op      (csrop_i[g]),
      .idx     (csrindex_i[g]),
      .data    (csrdata_i[g][7:0]),
      .fflagen (fflagen_i[g]),
      .fflag   (fflag_i[g]),
      .frm_in  (frm_c[g]),
      .ffl_in  (ffl_c[g]),
      .frm_out (frm_c[g+1]),
      .ffl_out (ffl_c[g+1]),
      .touch   (touch[g])
    );
    // No view uses operand bits above [7:0].
    assign unused_hi[g] = ^csrdata_i[g][XLEN-1:8];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      frm_q   <= FRM_RST;
      ffl_q   <= 5'b00000;
      dirty_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      frm_q <= frm_c[NLANE];
      ffl_q <= ffl_c[NLANE];
      // A set in the same cycle takes priority over fs_clr_i.
      if (|touch)        dirty_q <= 1'b1;
      else if (fs_clr_i) dirty_q <= 1'b0;
      // Only a net change of frm across all lanes restarts the flush window.
      if ((FLUSH_CYC > 0) && (frm_c[NLANE] != frm_q)) cnt_q <= CW'(FLUSH_CYC);
      else if (cnt_q != '0)                            cnt_q <= cnt_q - CW'(1);
    end
  end

  assign frm_o       = frm_q;
  assign fflags_o    = ffl_q;
  assign fcsr_o      = {{(XLEN-8){1'b0}}, frm_q, ffl_q};
  assign fs_dirty_o  = dirty_q;
  assign frm_stall_o = (cnt_q != '0);

  // The read port sees only the registered state. Commits in the same cycle are not forwarded.
  always_comb begin
    rd_data_o = '0;
    rd_hit_o  = 1'b0;
    case (rd_index_i)
      12'h001: begin rd_data_o = {{(XLEN-5){1'b0}}, ffl_q}; rd_hit_o = 1'b1; end
      12'h002: begin rd_data_o = {{(XLEN-3){1'b0}}, frm_q}; rd_hit_o = 1'b1; end
      12'h003: begin rd_data_o = fcsr_o;                    rd_hit_o = 1'b1; end
      default: ;
    endcase
  end

  assign rm_eff_o     = (rm_i == 3'b111) ? frm_q : rm_i;
  assign rm_illegal_o = (rm_eff_o == 3'b101) || (rm_eff_o == 3'b110) ||
                        (rm_eff_o == 3'b111);
endmodule

// File: tb/tb_fpcsr_mc.sv
module tb_fpcsr_mc;
  logic             clk_i = 1'b0;
  logic             srst_i;
  logic [1:0]       valid_i, csren_i, fflagen_i;
  logic [1:0][1:0]  csrop_i;
  logic [1:0][11:0] csrindex_i;
  logic [1:0][63:0] csrdata_i;
  logic [1:0][4:0]  fflag_i;
  logic             fs_clr_i;
  logic [11:0]      rd_index_i;
  logic [2:0]       rm_i;
  logic [63:0]      rd_data_o, fcsr_o;
  logic             rd_hit_o, fs_dirty_o, frm_stall_o, rm_illegal_o;
  logic [2:0]       frm_o, rm_eff_o;
  logic [4:0]       fflags_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  fpcsr_mc #(.XLEN(64), .NLANE(2), .FRM_RST(3'b000), .FLUSH_CYC(2)) dut (
    .clk_i(clk_i), .srst_i(srst_i), .valid_i(valid_i), .csren_i(csren_i),
    .csrop_i(csrop_i), .csrindex_i(csrindex_i), .csrdata_i(csrdata_i),
    .fflagen_i(fflagen_i), .fflag_i(fflag_i), .fs_clr_i(fs_clr_i),
    .rd_index_i(rd_index_i), .rm_i(rm_i), .rd_data_o(rd_data_o),
    .rd_hit_o(rd_hit_o), .fcsr_o(fcsr_o), .frm_o(frm_o), .fflags_o(fflags_o),
    .fs_dirty_o(fs_dirty_o), .frm_stall_o(frm_stall_o), .rm_eff_o(rm_eff_o),
    .rm_illegal_o(rm_illegal_o)
  );

  typedef struct packed {
    logic [1:0]       val, cen, fen;
    logic [1:0][1:0]  op;
    logic [1:0][11:0] idx;
    logic [1:0][7:0]  d;
    logic [1:0][4:0]  f;
    logic             clr;
    logic [4:0]       effl;
    logic [2:0]       efrm;
    logic             edirty, estall;
  } vec_t;

  localparam int WR = 1, ST = 2, CL = 3;
  localparam logic [55:0] JUNK = 56'ha5a5a5a5a5a5a5;

  vec_t vt[$];

  // The arguments are ordered lane1 then lane0, which matches the packed order.
  function automatic vec_t mk(int val, int cen, int op1, int op0, int i1, int i0,
                              int d1, int d0, int fen, int f1, int f0, int clr,
                              int effl, int efrm, int edirty, int estall);
    vec_t v;
    v.val = 2'(val); v.cen = 2'(cen); v.fen = 2'(fen);
    v.op[1] = 2'(op1);   v.op[0] = 2'(op0);
    v.idx[1] = 12'(i1);  v.idx[0] = 12'(i0);
    v.d[1] = 8'(d1);     v.d[0] = 8'(d0);
    v.f[1] = 5'(f1);     v.f[0] = 5'(f0);
    v.clr = 1'(clr);
    v.effl = 5'(effl); v.efrm = 3'(efrm);
    v.edirty = 1'(edirty); v.estall = 1'(estall);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    valid_i = '0; csren_i = '0; fflagen_i = '0; csrop_i = '0;
    csrindex_i = '0; csrdata_i = '0; fflag_i = '0; fs_clr_i = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    valid_i = v.val; csren_i = v.cen; fflagen_i = v.fen; csrop_i = v.op;
    csrindex_i = v.idx; fflag_i = v.f; fs_clr_i = v.clr;
    csrdata_i[1] = {JUNK, v.d[1]};
    csrdata_i[0] = {JUNK, v.d[0]};
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  initial begin
    idle();
    srst_i = 1'b1; rd_index_i = 12'h003; rm_i = 3'b000;
    tick(); tick();
    srst_i = 1'b0;
    tick();
    chk("rst_fcsr", fcsr_o, 64'h0);
    chk("rst_stall", 64'(frm_stall_o), 64'h0);
    chk("rst_dirty", 64'(fs_dirty_o), 64'h0);
    chk("rst_rd3_data", rd_data_o, 64'h0);
    chk("rst_rd3_hit", 64'(rd_hit_o), 64'h1);

    // Each entry gives one cycle of inputs and the state expected after its clock edge.
    // The effl, efrm, dirty and stall columns are the last four arguments.
    vt.push_back(mk(3,0, 0,0, 0,0, 0,0, 3, 5'b10000,5'b00001, 0, 5'b10001,0,1,0));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 1, 5'b10001,0,0,0));
    vt.push_back(mk(3,2, WR,0, 1,0, 8'h02,0, 1, 0,5'b00100, 0, 5'b00010,0,1,0));
    vt.push_back(mk(3,1, 0,WR, 0,1, 0,8'h02, 2, 5'b00100,0, 0, 5'b00110,0,1,0));
    vt.push_back(mk(1,1, 0,CL, 0,1, 0,8'h1f, 0, 0,0, 0, 0,0,1,0));
    // op 00 and the non-FP index are both ignored, so lane0's flag accrual still applies.
    vt.push_back(mk(3,3, WR,0, 12'h300,1, 8'hff,8'h1f, 1, 0,5'b01000, 0, 5'b01000,0,1,0));
    // The rejected op and the invalid lane do not dirty the state, so the clear takes effect.
    vt.push_back(mk(1,3, WR,WR, 1,12'h300, 8'h1f,8'hff, 0, 0,0, 1, 5'b01000,0,0,0));
    // A lane accruing a zero flag still marks the state dirty, and this beats fs_clr.
    vt.push_back(mk(1,0, 0,0, 0,0, 0,0, 1, 0,0, 1, 5'b01000,0,1,0));
    // Writing 0x20 to fcsr clears fflags and sets frm to 001, which starts a 2-cycle stall.
    vt.push_back(mk(1,1, 0,WR, 0,3, 0,8'h20, 0, 0,0, 0, 0,1,1,1));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,1,1,1));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,1,1,0));
    vt.push_back(mk(1,1, 0,WR, 0,3, 0,8'h20, 0, 0,0, 0, 0,1,1,0));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,1,1,0));
    // A second change partway through a stall reloads the counter.
    vt.push_back(mk(1,1, 0,WR, 0,2, 0,3, 0, 0,0, 0, 0,3,1,1));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,3,1,1));
    vt.push_back(mk(2,2, WR,0, 2,0, 1,0, 0, 0,0, 0, 0,1,1,1));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,1,1,1));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,1,1,0));
    // Lane0 sets frm bit 100 and lane1 clears bit 001, taking frm from 001 to 100.
    vt.push_back(mk(3,3, CL,ST, 2,2, 1,4, 0, 0,0, 0, 0,4,1,1));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,4,1,1));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,4,1,0));
    // frm passes through 011 inside the cycle but ends unchanged, so there is no stall.
    vt.push_back(mk(3,3, WR,WR, 2,2, 4,3, 0, 0,0, 0, 0,4,1,0));
    vt.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0, 0,4,1,0));

    foreach (vt[i]) begin
      drive(vt[i]);
      tick();
      chk($sformatf("v%0d_fflags", i), 64'(fflags_o), 64'(vt[i].effl));
      chk($sformatf("v%0d_frm", i), 64'(frm_o), 64'(vt[i].efrm));
      chk($sformatf("v%0d_fcsr", i), fcsr_o, {56'h0, vt[i].efrm, vt[i].effl});
      chk($sformatf("v%0d_dirty", i), 64'(fs_dirty_o), 64'(vt[i].edirty));
      chk($sformatf("v%0d_stall", i), 64'(frm_stall_o), 64'(vt[i].estall));
    end

    // The state is now frm=100, fflags=0. The read port must not forward a same-cycle write.
    drive(mk(1,1, 0,WR, 0,1, 0,8'h1f, 0, 0,0, 0, 0,0,0,0));
    rd_index_i = 12'h001; #1;
    chk("rd1_nobypass", rd_data_o, 64'h0);
    chk("rd1_hit", 64'(rd_hit_o), 64'h1);
    tick(); idle(); #1;
    chk("rd1_after", rd_data_o, 64'h1f);
    rd_index_i = 12'h002; #1;
    chk("rd2", rd_data_o, 64'h4);
    rd_index_i = 12'h003; #1;
    chk("rd3", rd_data_o, 64'h9f);
    rd_index_i = 12'h7ff; #1;
    chk("rd_miss_data", rd_data_o, 64'h0);
    chk("rd_miss_hit", 64'(rd_hit_o), 64'h0);

    rm_i = 3'b111; #1;
    chk("rm_dyn_eff", 64'(rm_eff_o), 64'h4);
    chk("rm_dyn_ill", 64'(rm_illegal_o), 64'h0);
    rm_i = 3'b110; #1;
    chk("rm110_ill", 64'(rm_illegal_o), 64'h1);
    rm_i = 3'b010; #1;
    chk("rm010_eff", 64'(rm_eff_o), 64'h2);
    chk("rm010_ill", 64'(rm_illegal_o), 64'h0);

    // Writing frm=101 makes the dynamic rounding mode illegal and starts a stall.
    drive(mk(1,1, 0,WR, 0,2, 0,5, 0, 0,0, 0, 0,0,0,0));
    tick(); idle();
    rm_i = 3'b111; #1;
    chk("frm101", 64'(frm_o), 64'h5);
    chk("rm_dyn101_eff", 64'(rm_eff_o), 64'h5);
    chk("rm_dyn101_ill", 64'(rm_illegal_o), 64'h1);
    chk("stall_pre_rst", 64'(frm_stall_o), 64'h1);

    // Reset arrives during the stall with a same-cycle commit, and reset takes priority.
    drive(mk(1,1, 0,WR, 0,3, 0,8'hff, 1, 0,5'b11111, 0, 0,0,0,0));
    srst_i = 1'b1;
    tick();
    srst_i = 1'b0; idle(); #1;
    chk("rst2_fcsr", fcsr_o, 64'h0);
    chk("rst2_stall", 64'(frm_stall_o), 64'h0);
    chk("rst2_dirty", 64'(fs_dirty_o), 64'h0);
    tick();
    chk("rst2_idle_stall", 64'(frm_stall_o), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
